uart_num_rx: RTL and testbench
==============================

# uart_num_rx

Receive-side counterpart of the on-board UART text reporter. Deserialises 8N1 UART bytes from the host, parses newline-terminated ASCII decimal lines (1–4 digits, e.g. "1234\r\n"), and presents the parsed value as a 16-bit word with a one-cycle valid strobe. Sits between the board RX pin and user logic that needs host-set thresholds or distances, such as the HC-SR04 alarm limit in mm. Also exposes raw bytes and error strobes for debug.

## Interface
- CLK_FRE, 50, system clock frequency in MHz
- UART_RATE, 115200, baud rate; bit period CYCLE = CLK_FRE*1_000_000/UART_RATE clocks (434 at defaults)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- uart_rx  in  1  asynchronous serial line, idle high
- rx_byte  out  8  last correctly framed byte
- rx_valid  out  1  one-cycle strobe, rx_byte updated
- data  out  16  last successfully parsed value, 0–9999
- data_valid  out  1  one-cycle strobe, data updated
- frame_err  out  1  one-cycle strobe, stop bit sampled low
- parse_err  out  1  one-cycle strobe, terminated line rejected

## Operation
- Input: 2-FF synchroniser, both FFs reset to 0, plus a previous-sample register reset to 0. Start condition = previous 1, current 0. A line held low through reset never triggers; a high sample is required first.
- Bit FSM states: IDLE, START, DATA, STOP. Bit counter and baud counter are sized for CYCLE.
  - IDLE -> START on a start condition; baud counter cleared.
  - START: at count CYCLE/2-1, sample. If low, -> DATA with the counter cleared. If high, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every CYCLE clocks and shift LSB first. After bit 7 -> STOP.
  - STOP: sample after CYCLE clocks. High: rx_byte <= byte and rx_valid pulses. Low: frame_err pulses, the byte is discarded, and the line error flag is set. Either way -> IDLE on the same edge, so back-to-back frames are accepted.
- Parser acts on each rx_valid byte:
  - '0'–'9': if digit_cnt < 4, acc <= acc*10 + digit and digit_cnt++; otherwise set err flag. acc*10 is computed as (acc<<3)+(acc<<1) in 14 bits.
  - '\r' and ' ' are ignored.
  - '\n': if digit_cnt >= 1 and err is clear, data <= acc and data_valid pulses; otherwise parse_err pulses. In all cases acc, digit_cnt and err are cleared.
  - Any other byte sets err.
- A frame_err sets err, so the current line is rejected at its '\n'.
- An empty line "\n" produces parse_err.
- data holds its value until the next successful line. It is not changed by errors.

## Timing
- Reset values: rx_byte=0, rx_valid=0, data=0, data_valid=0, frame_err=0, parse_err=0. Parser state is cleared and the FSM is in IDLE.
- Reset mid-frame: the partial byte and partial line are discarded. Reception restarts only after the line is seen high and then a new falling edge occurs.
- Start detect latency: 2 clocks (synchroniser) plus 1 clock (edge register) after the pin falls.
- Sample points fall at CYCLE/2 + n*CYCLE after detect, n = 1..8 for data and n = 9 for stop.
- rx_valid or frame_err is high for the single cycle after the stop-sample edge.
- data_valid or parse_err is high for the single cycle after the rx_valid cycle for '\n'. data is stable in that cycle.
- Strobes are never asserted for 2 consecutive cycles.
- Tolerance: correct reception with up to ±2% baud mismatch.

## Test plan
- Send "1234\r\n" at 115200 (CYCLE=434). Required: six rx_valid pulses with bytes 0x31,0x32,0x33,0x34,0x0D,0x0A; one data_valid with data=1234; no error strobes.
- Send "0\n" then "9999\n" back-to-back with no idle between frames. Required: data_valid with data=0, then data_valid with data=9999.
- Send "12345\n". Required: parse_err once, no data_valid, and data keeps its prior value. Then send "12a4\n" then "56\n". Required: parse_err, then data=56 with data_valid.
- Drive a 100-clock low glitch on idle uart_rx. Required: no rx_valid and no frame_err. Then send a frame with stop bit low inside "7X\n" (X corrupted), followed by "\n". Required: frame_err, then parse_err, then no data_valid.
- Assert rst_n low for 3 clocks during bit 4 of '5' in "5\n", then release and send "42\n". Required: all outputs 0 during reset, no strobe for the aborted frame, then data=42 with data_valid.
- Send "88\n" at baud +2% and at baud -2%. Required: data=88 with data_valid in both cases.

Source files
------------

// File: rtl/uart_num_rx.sv
// rtl/uart_num_rx.sv - 8N1 UART receiver with newline-terminated decimal line parser
// Emits raw bytes, framing/parse error strobes and a 16-bit parsed value (0-9999).
module uart_num_rx #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic [15:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        parse_err
);

    localparam int CYCLE = CLK_FRE * 1000000 / UART_RATE;
    localparam int CNT_W = $clog2(CYCLE);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;

    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_prev;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_byte;
    logic             r_rx_valid;
    logic             r_frame_err;

    logic [13:0]      r_acc;
    logic [2:0]       r_digit_cnt;
    logic             r_err;
    logic [15:0]      r_data;
    logic             r_data_valid;
    logic             r_parse_err;

    logic             w_start;
    logic             w_baud_done;
    logic             w_is_digit;
    logic [13:0]      w_acc_x10;
    logic [13:0]      w_acc_next;

    // Synchroniser and edge register reset low, so a line held low through reset cannot start a frame.
    assign w_start     = r_rx_prev & ~r_rx_s2;
    assign w_baud_done = (r_baud_cnt == FULL_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1     <= 1'b0;
            r_rx_s2     <= 1'b0;
            r_rx_prev   <= 1'b0;
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_rx_byte   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_s1     <= uart_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_prev   <= r_rx_s2;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_START;
                        r_baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_baud_cnt == HALF_M1) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {r_rx_s2, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                        if (r_rx_s2) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_is_digit = (r_rx_byte >= CH_ZERO) && (r_rx_byte <= CH_NINE);
    assign w_acc_x10  = {r_acc[10:0], 3'b000} + {r_acc[12:0], 1'b0};
    assign w_acc_next = w_acc_x10 + {10'd0, r_rx_byte[3:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc        <= 14'd0;
            r_digit_cnt  <= 3'd0;
            r_err        <= 1'b0;
            r_data       <= 16'd0;
            r_data_valid <= 1'b0;
            r_parse_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_parse_err  <= 1'b0;
            if (r_frame_err) begin
                r_err <= 1'b1;
            end else if (r_rx_valid) begin
                if (w_is_digit) begin
                    if (r_digit_cnt < 3'd4) begin
                        r_acc       <= w_acc_next;
                        r_digit_cnt <= r_digit_cnt + 3'd1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else if (r_rx_byte == CH_LF) begin
                    if ((r_digit_cnt != 3'd0) && !r_err) begin
                        r_data       <= {2'b00, r_acc};
                        r_data_valid <= 1'b1;
                    end else begin
                        r_parse_err <= 1'b1;
                    end
                    r_acc       <= 14'd0;
                    r_digit_cnt <= 3'd0;
                    r_err       <= 1'b0;
                end else if ((r_rx_byte != CH_CR) && (r_rx_byte != CH_SPACE)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign rx_byte    = r_rx_byte;
    assign rx_valid   = r_rx_valid;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign parse_err  = r_parse_err;

endmodule

// File: tb/tb_uart_num_rx.sv
// tb/tb_uart_num_rx.sv - directed bench for uart_num_rx
// 100 MHz clock with a 40-clock bit period.
`timescale 1ns/1ps
module tb_uart_num_rx;

    localparam real BIT_NS = 400.0;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        parse_err;

    int total;
    int bad;

    logic [7:0]  rxq[$];
    logic [15:0] dq[$];
    int          n_fe;
    int          n_pe;
    int          n_dbl;
    logic        p_rxv, p_dv, p_fe, p_pe;

    uart_num_rx #(.CLK_FRE(100), .UART_RATE(2500000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parse_err  (parse_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe logger; sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)   rxq.push_back(rx_byte);
            if (data_valid) dq.push_back(data);
            if (frame_err)  n_fe++;
            if (parse_err)  n_pe++;
            if ((rx_valid && p_rxv) || (data_valid && p_dv) || (frame_err && p_fe) || (parse_err && p_pe))
                n_dbl++;
        end
        p_rxv = rx_valid;
        p_dv  = data_valid;
        p_fe  = frame_err;
        p_pe  = parse_err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rxq.delete();
        dq.delete();
        n_fe = 0;
        n_pe = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input real bit_ns);
        uart_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(bit_ns);
        end
        uart_rx = stop;
        #(bit_ns);
        if (!stop) begin
            uart_rx = 1'b1;
            #(2.0 * bit_ns);
        end
    endtask

    task automatic send_str(input string s, input real bit_ns);
        @(negedge clk);
        for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, bit_ns);
        uart_rx = 1'b1;
        #(2.0 * bit_ns);
    endtask

    function automatic int outs_or();
        return int'({rx_byte, rx_valid, data, data_valid, frame_err, parse_err} != 29'd0);
    endfunction

    initial begin
        logic [7:0] exp_bytes [6];
        total   = 0;
        bad     = 0;
        n_dbl   = 0;
        p_rxv   = 1'b0;
        p_dv    = 1'b0;
        p_fe    = 1'b0;
        p_pe    = 1'b0;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        clear_log();
        repeat (4) @(negedge clk);
        check("reset_rx_byte", int'(rx_byte), 0);
        check("reset_data", int'(data), 0);
        check("reset_strobes", int'({rx_valid, data_valid, frame_err, parse_err}), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // "1234\r\n"
        clear_log();
        send_str("1234\r\n", BIT_NS);
        exp_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        check("l1234_nbytes", rxq.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("l1234_byte%0d", i), (i < rxq.size()) ? int'(rxq[i]) : -1, int'(exp_bytes[i]));
        check("l1234_ndv", dq.size(), 1);
        check("l1234_val", (dq.size() > 0) ? int'(dq[0]) : -1, 1234);
        check("l1234_errs", n_fe + n_pe, 0);

        // back-to-back "0\n9999\n"
        clear_log();
        send_str("0\n9999\n", BIT_NS);
        check("b2b_ndv", dq.size(), 2);
        check("b2b_val0", (dq.size() > 0) ? int'(dq[0]) : -1, 0);
        check("b2b_val1", (dq.size() > 1) ? int'(dq[1]) : -1, 9999);
        check("b2b_hold", int'(data), 9999);

        // five digits
        clear_log();
        send_str("12345\n", BIT_NS);
        check("five_pe", n_pe, 1);
        check("five_ndv", dq.size(), 0);
        check("five_hold", int'(data), 9999);

        // bad char then recovery
        clear_log();
        send_str("12a4\n56\n", BIT_NS);
        check("alpha_pe", n_pe, 1);
        check("alpha_ndv", dq.size(), 1);
        check("alpha_val", (dq.size() > 0) ? int'(dq[0]) : -1, 56);

        // glitch on idle line, then framing error in a line
        clear_log();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (15) @(negedge clk);
        uart_rx = 1'b1;
        #(3.0 * BIT_NS);
        check("glitch_rx", rxq.size(), 0);
        check("glitch_fe", n_fe, 0);
        @(negedge clk);
        send_frame("7", 1'b1, BIT_NS);
        send_frame("X", 1'b0, BIT_NS);
        send_str("\n\n", BIT_NS);
        check("ferr_fe", n_fe, 1);
        check("ferr_pe", n_pe, 2);
        check("ferr_ndv", dq.size(), 0);
        check("ferr_nbytes", rxq.size(), 3);
        check("ferr_hold", int'(data), 56);

        // reset during bit 4 of '5', after a '9' is already accumulated
        clear_log();
        send_str("9", BIT_NS);
        @(negedge clk);
        uart_rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (8'h35 >> i) & 8'h01;
            #(BIT_NS);
        end
        uart_rx = 1'b1;
        #(BIT_NS / 2.0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst_outs%0d", i), outs_or(), 0);
        end
        rst_n = 1'b1;
        #(3.0 * BIT_NS);
        check("midrst_nbytes", rxq.size(), 1);
        send_str("42\n", BIT_NS);
        check("midrst_ndv", dq.size(), 1);
        check("midrst_val", (dq.size() > 0) ? int'(dq[0]) : -1, 42);
        check("midrst_errs", n_fe + n_pe, 0);

        // baud tolerance
        clear_log();
        send_str("88\n", BIT_NS * 1.02);
        check("fast_ndv", dq.size(), 1);
        check("fast_val", (dq.size() > 0) ? int'(dq[0]) : -1, 88);
        clear_log();
        data_hold_break: begin end
        send_str("7\n", BIT_NS);
        clear_log();
        send_str("88\n", BIT_NS * 0.98);
        check("slow_ndv", dq.size(), 1);
        check("slow_val", (dq.size() > 0) ? int'(dq[0]) : -1, 88);
        check("tol_errs", n_fe + n_pe, 0);

        check("strobe_double", n_dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
